// File: rtl/vram_image_loader_pkg.sv
// Shared debugger package for the VRAM image loader.
// Holds the loader state encoding and the VRAM/image geometry constants
// used by the loader and anything that talks to it.
package vram_image_loader_pkg;

  localparam int VRAM_ADR_W = 14;
  localparam int IMAGE_SIZE = 16384;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_WAIT  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/vram_image_loader.sv
// Debugger-side sequencer that copies the image ROM into VRAM on command.
// Each byte costs FETCH (ROM address stable), WAIT (ROM data valid, latched)
// and WRITE (VRAM req/ack handshake). While a load runs the normal VRAM
// requester is locked out through ext_ack.
//
// Ports:
//   clk, reset       system clock, synchronous active-high reset
//   start, abort     one-cycle command pulses from the debugger
//   busy, done       load in progress / one-cycle completion pulse
//   rom_adr, rom_dbi image ROM address out, data in (1-cycle latency)
//   vram_req/ack     VRAM write handshake; vram_adr/vram_wdata held in WRITE
//   ext_req/ext_ack  normal VRAM requester, granted only while not busy
module vram_image_loader
  import vram_image_loader_pkg::*;
#(
  parameter int ROM_START  = 0,
  parameter int BYTE_COUNT = IMAGE_SIZE,
  parameter int VRAM_BASE  = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic [VRAM_ADR_W-1:0] rom_adr,
  input  logic [7:0]            rom_dbi,
  output logic                  vram_req,
  input  logic                  vram_ack,
  output logic [VRAM_ADR_W-1:0] vram_adr,
  output logic [7:0]            vram_wdata,
  input  logic                  ext_req,
  output logic                  ext_ack
);

  // One bit wider than an address so a full-image count is representable.
  localparam int CNT_W = VRAM_ADR_W + 1;

  localparam logic [VRAM_ADR_W-1:0] ROM_START_A = VRAM_ADR_W'(ROM_START);
  localparam logic [VRAM_ADR_W-1:0] VRAM_BASE_A = VRAM_ADR_W'(VRAM_BASE);
  localparam logic [CNT_W-1:0]      LAST_CNT    = CNT_W'(BYTE_COUNT - 1);

  state_t                  r_state;
  logic                    r_busy;
  logic                    r_done;
  logic                    r_req;
  logic [VRAM_ADR_W-1:0]   r_rom_adr;
  logic [VRAM_ADR_W-1:0]   r_vram_adr;
  logic [7:0]              r_wdata;
  logic [CNT_W-1:0]        r_cnt;

  // r_req is only ever high in WRITE, so an ack outside WRITE is ignored.
  logic                    w_xfer;
  assign w_xfer = r_req & vram_ack;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_req      <= 1'b0;
      r_rom_adr  <= ROM_START_A;
      r_vram_adr <= VRAM_BASE_A;
      r_wdata    <= '0;
      r_cnt      <= '0;
    end else begin
      r_done <= 1'b0;

      // A completed handshake always advances, even when abort arrives in
      // the same cycle. Addresses wrap naturally at 14 bits.
      if (w_xfer) begin
        r_cnt      <= r_cnt + 1'b1;
        r_rom_adr  <= r_rom_adr + 1'b1;
        r_vram_adr <= r_vram_adr + 1'b1;
      end

      unique case (r_state)
        ST_IDLE: begin
          // Abort is meaningless here, so start always wins.
          if (start) begin
            r_rom_adr  <= ROM_START_A;
            r_vram_adr <= VRAM_BASE_A;
            r_cnt      <= '0;
            r_busy     <= 1'b1;
            r_state    <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (abort) begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (abort) begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_wdata <= rom_dbi;
            r_req   <= 1'b1;
            r_state <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (abort) begin
            r_req   <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else if (w_xfer) begin
            r_req <= 1'b0;
            if (r_cnt == LAST_CNT) begin
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= ST_DONE;
            end else begin
              r_state <= ST_FETCH;
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_req   <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign vram_req   = r_req;
  assign rom_adr    = r_rom_adr;
  assign vram_adr   = r_vram_adr;
  assign vram_wdata = r_wdata;
  assign ext_ack    = ext_req & ~r_busy;

endmodule

// File: tb/tb_vram_image_loader.sv
// Self-checking bench for vram_image_loader: a default-parameter instance (A)
// and a wrapping, short-load instance (B) with random ROM content.
module tb_vram_image_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  // Instance A: default parameters
  logic        a_reset, a_start, a_abort, a_busy, a_done;
  logic [13:0] a_rom_adr, a_vadr;
  logic [7:0]  a_rom_dbi, a_wdata;
  logic        a_req, a_ack, a_ext_req, a_ext_ack;

  // Instance B: ROM_START=16380, BYTE_COUNT=8, VRAM_BASE=100
  logic        b_reset, b_start, b_abort, b_busy, b_done;
  logic [13:0] b_rom_adr, b_vadr;
  logic [7:0]  b_rom_dbi, b_wdata;
  logic        b_req, b_ack, b_ext_req, b_ext_ack;

  vram_image_loader u_a (
    .clk(clk), .reset(a_reset), .start(a_start), .abort(a_abort),
    .busy(a_busy), .done(a_done), .rom_adr(a_rom_adr), .rom_dbi(a_rom_dbi),
    .vram_req(a_req), .vram_ack(a_ack), .vram_adr(a_vadr),
    .vram_wdata(a_wdata), .ext_req(a_ext_req), .ext_ack(a_ext_ack)
  );

  vram_image_loader #(.ROM_START(16380), .BYTE_COUNT(8), .VRAM_BASE(100)) u_b (
    .clk(clk), .reset(b_reset), .start(b_start), .abort(b_abort),
    .busy(b_busy), .done(b_done), .rom_adr(b_rom_adr), .rom_dbi(b_rom_dbi),
    .vram_req(b_req), .vram_ack(b_ack), .vram_adr(b_vadr),
    .vram_wdata(b_wdata), .ext_req(b_ext_req), .ext_ack(b_ext_ack)
  );

  // Registered image ROMs: A returns the address low byte, B random content.
  logic [7:0] rom_b [16384];
  always @(posedge clk) a_rom_dbi <= a_rom_adr[7:0];
  always @(posedge clk) b_rom_dbi <= rom_b[b_rom_adr];

  typedef struct { logic [13:0] adr; logic [7:0] dat; } wr_t;
  wr_t qa[$];
  wr_t qb[$];
  int a_done_cnt = 0, b_done_cnt = 0;
  int a_done_cyc = 0, b_done_cyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Monitor: inputs only change at posedge+1, so the negedge sees exactly
  // what the next posedge will sample.
  always @(negedge clk) begin
    cyc++;
    if (a_req && a_ack) qa.push_back('{a_vadr, a_wdata});
    if (b_req && b_ack) qb.push_back('{b_vadr, b_wdata});
    if (a_done) begin a_done_cnt++; a_done_cyc = cyc; end
    if (b_done) begin b_done_cnt++; b_done_cyc = cyc; end
    chk("a_ext_ack", a_ext_ack, a_busy ? 1'b0 : a_ext_req);
    chk("b_ext_ack", b_ext_ack, b_busy ? 1'b0 : b_ext_req);
  end

  function automatic logic [21:0] exp_b(input int k);
    return {14'((100 + k) % 16384), rom_b[(16380 + k) % 16384]};
  endfunction

  int  s, dc, ca, cd;
  bit  stalled;

  initial begin
    a_reset = 1; a_start = 0; a_abort = 0; a_ack = 1; a_ext_req = 1;
    b_reset = 1; b_start = 0; b_abort = 0; b_ack = 0; b_ext_req = 0;
    for (int i = 0; i < 16384; i++) rom_b[i] = 8'($urandom);
    repeat (3) @(posedge clk);
    #1;

    // Reset state
    chk("a_rst_busy", a_busy, 0);   chk("a_rst_done", a_done, 0);
    chk("a_rst_req", a_req, 0);     chk("a_rst_rom", a_rom_adr, 0);
    chk("a_rst_vadr", a_vadr, 0);   chk("a_rst_wdata", a_wdata, 0);
    chk("a_rst_ext", a_ext_ack, 1);
    chk("b_rst_busy", b_busy, 0);   chk("b_rst_req", b_req, 0);
    chk("b_rst_rom", b_rom_adr, 16380); chk("b_rst_vadr", b_vadr, 100);
    chk("b_rst_wdata", b_wdata, 0);
    a_reset = 0; b_reset = 0;
    @(posedge clk); #1;

    // A: abort after 10 completed writes
    a_start = 1; s = cyc + 1;
    @(posedge clk); #1; a_start = 0;
    chk("a_busy_after_start", a_busy, 1);
    for (int t = 0; t < 200 && qa.size() < 10; t++) begin @(posedge clk); #1; end
    chk("a_wr10", qa.size(), 10);
    a_abort = 1;
    @(posedge clk); #1; a_abort = 0;
    chk("a_abort_busy", a_busy, 0);
    chk("a_abort_req", a_req, 0);
    repeat (10) begin @(posedge clk); #1; end
    chk("a_abort_nodone", a_done_cnt, 0);
    chk("a_abort_nowr", qa.size(), 10);
    for (int k = 0; k < qa.size(); k++)
      chk("a_abort_wr", {qa[k].adr, qa[k].dat}, {14'(k), 8'(k)});

    // A: fresh full-image load, ack always 1, ext_req held 1
    qa.delete();
    a_start = 1; s = cyc + 1;
    @(posedge clk); #1; a_start = 0;
    for (int t = 0; t < 60000 && a_done_cnt == 0; t++) begin @(posedge clk); #1; end
    chk("a_full_done_cnt", a_done_cnt, 1);
    chk("a_full_done_cyc", a_done_cyc - s, 3 * 16384 + 1);
    chk("a_full_wr_cnt", qa.size(), 16384);
    for (int k = 0; k < qa.size(); k++)
      chk("a_full_wr", {qa[k].adr, qa[k].dat}, {14'(k), 8'(k)});
    repeat (3) begin @(posedge clk); #1; end
    chk("a_full_busy_after", a_busy, 0);
    chk("a_full_single_done", a_done_cnt, 1);
    chk("a_full_rom_wrap", a_rom_adr, 0);
    chk("a_full_ext_after", a_ext_ack, 1);

    // B: wrapping load with random ack stalls and random ext_req
    b_start = 1;
    @(posedge clk); #1; b_start = 0;
    for (int t = 0; t < 2000 && b_done_cnt == 0; t++) begin
      @(posedge clk); #1;
      b_ack = ($urandom_range(0, 2) != 0);
      b_ext_req = 1'($urandom_range(0, 1));
    end
    b_ack = 0;
    repeat (2) begin @(posedge clk); #1; end
    chk("b_wrap_done_cnt", b_done_cnt, 1);
    chk("b_wrap_wr_cnt", qb.size(), 8);
    for (int k = 0; k < qb.size(); k++)
      chk("b_wrap_wr", {qb[k].adr, qb[k].dat}, exp_b(k));
    chk("b_wrap_rom_end", b_rom_adr, 4);
    chk("b_wrap_vadr_end", b_vadr, 108);
    chk("b_wrap_busy", b_busy, 0);

    // B: 5-cycle ack stall on byte 2
    qb.delete(); b_ack = 1; stalled = 0;
    b_start = 1;
    @(posedge clk); #1; b_start = 0;
    for (int t = 0; t < 2000 && b_done_cnt == 1; t++) begin
      @(posedge clk); #1;
      if (!stalled && b_req && qb.size() == 2) begin
        b_ack = 0; ca = b_vadr; cd = b_wdata;
        chk("b_stall_adr", ca, 102);
        chk("b_stall_dat", cd, rom_b[16382]);
        repeat (5) begin
          @(posedge clk); #1;
          chk("b_stall_req", b_req, 1);
          chk("b_stall_vadr", b_vadr, ca);
          chk("b_stall_wdata", b_wdata, cd);
        end
        b_ack = 1; stalled = 1;
      end
    end
    chk("b_stall_seen", stalled, 1);
    chk("b_stall_done_cnt", b_done_cnt, 2);
    chk("b_stall_wr_cnt", qb.size(), 8);
    for (int k = 0; k < qb.size(); k++)
      chk("b_stall_wr", {qb[k].adr, qb[k].dat}, exp_b(k));

    // B: abort coinciding with the last handshake
    qb.delete(); b_ack = 1;
    b_start = 1;
    @(posedge clk); #1; b_start = 0;
    for (int t = 0; t < 200 && qb.size() < 7; t++) begin @(posedge clk); #1; end
    b_ack = 0;
    for (int t = 0; t < 20 && !b_req; t++) begin @(posedge clk); #1; end
    chk("b_lastabort_req", b_req, 1);
    b_ack = 1; b_abort = 1;
    @(posedge clk); #1; b_ack = 0; b_abort = 0;
    chk("b_lastabort_busy", b_busy, 0);
    chk("b_lastabort_reqlow", b_req, 0);
    chk("b_lastabort_wr_cnt", qb.size(), 8);
    chk("b_lastabort_vadr", b_vadr, 108);
    chk("b_lastabort_rom", b_rom_adr, 4);
    repeat (5) begin @(posedge clk); #1; end
    chk("b_lastabort_nodone", b_done_cnt, 2);

    // B: second start while busy, then reset mid-load
    qb.delete(); b_ack = 1; dc = b_done_cnt;
    b_start = 1;
    @(posedge clk); #1; b_start = 0;
    for (int t = 0; t < 200 && qb.size() < 3; t++) begin @(posedge clk); #1; end
    b_start = 1;
    @(posedge clk); #1; b_start = 0;
    chk("b_restart_busy", b_busy, 1);
    for (int t = 0; t < 200 && qb.size() < 6; t++) begin @(posedge clk); #1; end
    b_reset = 1;
    @(posedge clk); #1; b_reset = 0;
    chk("b_midrst_busy", b_busy, 0);  chk("b_midrst_done", b_done, 0);
    chk("b_midrst_req", b_req, 0);    chk("b_midrst_rom", b_rom_adr, 16380);
    chk("b_midrst_vadr", b_vadr, 100); chk("b_midrst_wdata", b_wdata, 0);
    repeat (40) begin @(posedge clk); #1; end
    chk("b_midrst_nodone", b_done_cnt, dc);
    chk("b_midrst_wr_cnt", qb.size(), 6);
    for (int k = 0; k < qb.size(); k++)
      chk("b_midrst_wr", {qb[k].adr, qb[k].dat}, exp_b(k));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
